// File: rtl/gain_shift_ctrl.sv
// Windowed peak-driven gain controller: measures the peak MSB over WINDOW accepted samples,
// then adjusts a saturating left-shift gain (fast attack, single-step release).
module gain_shift_ctrl #(
   parameter int WINDOW     = 1024,
   parameter int TARGET_BIT = 20,
   parameter int MAX_SHIFT  = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        enable,
   input  logic [23:0] sample_in,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic [23:0] sample_out,
   output logic        out_valid,
   output logic [3:0]  shift_out,
   output logic [4:0]  peak_pos,
   output logic        peak_silent,
   output logic        window_done
);

   localparam int CW = $clog2(WINDOW + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      UPDATE  = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic [CW-1:0] count_r;
   logic [23:0]   peak_r;
   logic [23:0]   mag_s;
   logic [4:0]    pos_s;
   logic [3:0]    desired_s;
   logic [3:0]    shift_next_s;
   logic          accept_s;
   logic          last_s;
   logic          measuring_s;

   function automatic logic [23:0] abs24(input logic [23:0] s);
      logic [23:0] r;
      if (s[23]) begin
         r = (~s) + 24'd1;
      end else begin
         r = s;
      end
      return r;
   endfunction

   function automatic logic [4:0] msb_pos(input logic [23:0] m);
      logic [4:0] p;
      p = 5'd0;
      for (int i = 0; i < 24; i++) begin
         if (m[i]) begin
            p = 5'(i);
         end
      end
      return p;
   endfunction

   function automatic logic [3:0] clamp_shift(input logic [4:0] pos);
      logic [4:0] diff;
      logic [3:0] r;
      if (pos >= 5'(TARGET_BIT)) begin
         r = 4'd0;
      end else begin
         diff = 5'(TARGET_BIT) - pos;
         if (diff > 5'(MAX_SHIFT)) begin
            r = 4'(MAX_SHIFT);
         end else begin
            r = 4'(diff);
         end
      end
      return r;
   endfunction

   // Sign-extend to 39 bits so a 15-bit shift cannot lose the overflow information.
   function automatic logic [23:0] sat_shift(input logic [23:0] s, input logic [3:0] sh);
      logic signed [38:0] w;
      logic [23:0]        r;
      w = 39'(signed'(s)) <<< sh;
      if (w > 39'sd8388607) begin
         r = 24'h7FFFFF;
      end else if (w < -39'sd8388608) begin
         r = 24'h800000;
      end else begin
         r = 24'(w);
      end
      return r;
   endfunction

   assign sample_ready = (state_r != UPDATE);
   assign accept_s     = sample_valid & sample_ready;
   assign measuring_s  = (state_r == MEASURE) & enable;
   assign last_s       = (count_r == CW'(WINDOW - 1));
   assign mag_s        = abs24(sample_in);
   assign pos_s        = msb_pos(peak_r);
   assign desired_s    = clamp_shift(pos_s);

   // Next-state logic for the measure/update sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) state_next_s = MEASURE;
            else        state_next_s = IDLE;
         end
         MEASURE: begin
            if (!enable)                state_next_s = IDLE;
            else if (accept_s && last_s) state_next_s = UPDATE;
            else                         state_next_s = MEASURE;
         end
         UPDATE: begin
            if (enable) state_next_s = MEASURE;
            else        state_next_s = IDLE;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Gain decision: attack jumps straight down, release climbs one step per window.
   always_comb begin
      shift_next_s = shift_out;
      if (peak_r == 24'd0) begin
         shift_next_s = shift_out;
      end else if (desired_s < shift_out) begin
         shift_next_s = desired_s;
      end else if (desired_s > shift_out) begin
         shift_next_s = shift_out + 4'd1;
      end else begin
         shift_next_s = shift_out;
      end
   end

   // State register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_r <= IDLE;
      else        state_r <= state_next_s;
   end

   // Window counter and running peak; anything outside an enabled MEASURE discards the window.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         count_r <= '0;
         peak_r  <= 24'd0;
      end else if (measuring_s) begin
         if (accept_s) begin
            count_r <= count_r + CW'(1);
            if (mag_s > peak_r) peak_r <= mag_s;
         end
      end else begin
         count_r <= '0;
         peak_r  <= 24'd0;
      end
   end

   // Window-end results.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         shift_out   <= 4'd0;
         peak_pos    <= 5'd0;
         peak_silent <= 1'b1;
         window_done <= 1'b0;
      end else if (state_r == UPDATE) begin
         shift_out   <= shift_next_s;
         peak_pos    <= pos_s;
         peak_silent <= (peak_r == 24'd0);
         window_done <= 1'b1;
      end else begin
         window_done <= 1'b0;
      end
   end

   // Output datapath, one cycle behind the accepted sample.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sample_out <= 24'd0;
         out_valid  <= 1'b0;
      end else if (accept_s) begin
         out_valid  <= 1'b1;
         sample_out <= measuring_s ? sat_shift(sample_in, shift_out) : sample_in;
      end else begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gain_shift_ctrl.sv
// Randomized and directed bench for gain_shift_ctrl against a behavioural reference model.
module tb_gain_shift_ctrl;

   localparam int WIN  = 8;
   localparam int TGT  = 20;
   localparam int MAXS = 8;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        enable;
   logic [23:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic [23:0] sample_out;
   logic        out_valid;
   logic [3:0]  shift_out;
   logic [4:0]  peak_pos;
   logic        peak_silent;
   logic        window_done;

   gain_shift_ctrl #(.WINDOW(WIN), .TARGET_BIT(TGT), .MAX_SHIFT(MAXS)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_out(sample_out),
      .out_valid(out_valid), .shift_out(shift_out), .peak_pos(peak_pos),
      .peak_silent(peak_silent), .window_done(window_done)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0 idle, 1 measuring, 2 window update
   int          m_mode, m_cnt, m_shift, e_pos;
   longint      m_peak;
   logic [23:0] e_out;
   bit          e_valid, e_sil, e_done, m_acc;
   int          n_acc, n_pulses;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int bpos(input longint m);
      int p = 0;
      for (int i = 0; i < 24; i++) if (m >= (longint'(1) << i)) p = i;
      return p;
   endfunction

   function automatic logic [23:0] sat_ref(input logic [23:0] d, input int sh);
      longint v = longint'(signed'(d)) * (longint'(1) << sh);
      if (v > 64'sd8388607)  return 24'h7FFFFF;
      if (v < -64'sd8388608) return 24'h800000;
      return 24'(v);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_peak = 0; m_shift = 0;
      e_pos = 0; e_sil = 1'b1; e_done = 1'b0; e_valid = 1'b0; e_out = 24'd0; m_acc = 1'b0;
   endtask

   task automatic model_edge(input bit en, input bit v, input logic [23:0] d);
      longint sv, mag;
      int     des;
      m_acc  = v && (m_mode != 2);
      e_done = 1'b0;
      if (m_acc) begin
         e_valid = 1'b1;
         e_out   = (m_mode == 1 && en) ? sat_ref(d, m_shift) : d;
         n_acc++;
      end else begin
         e_valid = 1'b0;
      end
      case (m_mode)
         2: begin
            e_pos = bpos(m_peak);
            e_sil = (m_peak == 0);
            if (!e_sil) begin
               des = TGT - e_pos;
               if (des < 0) des = 0;
               if (des > MAXS) des = MAXS;
               if (des < m_shift)      m_shift = des;
               else if (des > m_shift) m_shift = m_shift + 1;
            end
            e_done = 1'b1;
            m_cnt = 0; m_peak = 0;
            m_mode = en ? 1 : 0;
         end
         1: begin
            if (!en) begin
               m_mode = 0; m_cnt = 0; m_peak = 0;
            end else if (m_acc) begin
               sv  = longint'(signed'(d));
               mag = (sv < 0) ? -sv : sv;
               if (mag > m_peak) m_peak = mag;
               m_cnt++;
               if (m_cnt == WIN) m_mode = 2;
            end
         end
         default: begin
            m_mode = en ? 1 : 0; m_cnt = 0; m_peak = 0;
         end
      endcase
   endtask

   task automatic compare_all();
      check_val("out_valid", out_valid, e_valid);
      check_val("sample_out", sample_out, e_out);
      check_val("shift_out", shift_out, 32'(m_shift));
      check_val("peak_pos", peak_pos, 32'(e_pos));
      check_val("peak_silent", peak_silent, e_sil);
      check_val("window_done", window_done, e_done);
      if (out_valid) n_pulses++;
   endtask

   task automatic step(input bit en, input bit v, input logic [23:0] d);
      enable = en; sample_valid = v; sample_in = d;
      #1;
      check_val("sample_ready", sample_ready, (m_mode != 2));
      @(posedge clk_in);
      model_edge(en, v, d);
      #1;
      compare_all();
   endtask

   // Offer one sample, holding it until the model says it was taken.
   task automatic push(input bit en, input logic [23:0] d);
      bit done = 1'b0;
      for (int k = 0; k < 4 && !done; k++) begin
         step(en, 1'b1, d);
         done = m_acc;
      end
      if (!done) check_val("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic window(input logic [23:0] peak_val);
      logic [23:0] s;
      for (int i = 0; i < WIN; i++) begin
         if (i == 3 || peak_val == 24'd0) begin
            s = (i == 3) ? peak_val : 24'd0;
         end else begin
            s = 24'($urandom_range(0, 32'h7FF));
            if ($urandom_range(0, 1) == 1) s = -s;
         end
         push(1'b1, s);
      end
      step(1'b1, 1'b0, 24'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_out"}, sample_out, 24'd0);
      check_val({tag, "_valid"}, out_valid, 1'b0);
      check_val({tag, "_shift"}, shift_out, 4'd0);
      check_val({tag, "_pos"}, peak_pos, 5'd0);
      check_val({tag, "_silent"}, peak_silent, 1'b1);
      check_val({tag, "_done"}, window_done, 1'b0);
   endtask

   initial begin
      logic [23:0] r;
      rst_in = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_in = 24'd0;
      n_acc = 0; n_pulses = 0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check_reset_outputs("reset");
      rst_in = 1'b0;
      step(1'b1, 1'b0, 24'd0);

      // Release: one step per window up to MAX_SHIFT, then held
      for (int w = 1; w <= 9; w++) begin
         window(24'h001000);
         check_val("rel_done", window_done, 1'b1);
         check_val("rel_pos", peak_pos, 5'd12);
         check_val("rel_shift", shift_out, 32'((w > MAXS) ? MAXS : w));
      end

      // Attack straight to zero, and the next sample goes through unshifted
      window(24'h400000);
      check_val("atk_pos", peak_pos, 5'd22);
      check_val("atk_shift", shift_out, 4'd0);
      push(1'b1, 24'h000123);
      check_val("atk_next", sample_out, 24'h000123);
      for (int i = 0; i < WIN - 1; i++) push(1'b1, 24'h001000);
      step(1'b1, 1'b0, 24'd0);
      window(24'h001000);
      window(24'h001000);
      check_val("sat_setup", shift_out, 4'd3);

      // Saturation at shift 3
      push(1'b1, 24'h200000);
      check_val("sat_pos", sample_out, 24'h7FFFFF);
      push(1'b1, 24'hE00000);
      check_val("sat_neg", sample_out, 24'h800000);
      push(1'b1, 24'h000010);
      check_val("sat_none", sample_out, 24'h000080);
      for (int i = 0; i < WIN - 3; i++) push(1'b1, 24'h000001);
      step(1'b1, 1'b0, 24'd0);

      // Silence holds the shift; full-scale negative reports bit 23
      window(24'h001000);
      window(24'd0);
      check_val("sil_flag", peak_silent, 1'b1);
      check_val("sil_pos", peak_pos, 5'd0);
      check_val("sil_shift", shift_out, 4'd1);
      window(24'h800000);
      check_val("min_pos", peak_pos, 5'd23);
      check_val("min_silent", peak_silent, 1'b0);

      // Disruption: partial window discarded, passthrough unshifted
      window(24'h001000);
      for (int i = 0; i < 5; i++) push(1'b1, 24'h000100);
      push(1'b0, 24'h001001);
      check_val("dis_pass", sample_out, 24'h001001);
      check_val("dis_nodone", window_done, 1'b0);
      step(1'b1, 1'b0, 24'd0);
      for (int i = 0; i < WIN - 1; i++) push(1'b1, 24'h000100);
      step(1'b1, 1'b0, 24'd0);
      check_val("dis_short", window_done, 1'b0);
      push(1'b1, 24'h000100);
      step(1'b1, 1'b0, 24'd0);
      check_val("dis_full", window_done, 1'b1);

      // Reset mid-window takes effect without a clock edge
      for (int i = 0; i < 3; i++) push(1'b1, 24'h004000);
      rst_in = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;

      // Randomized traffic with occasional enable drops and valid gaps
      for (int c = 0; c < 600; c++) begin
         r = 24'($urandom) >> $urandom_range(0, 23);
         if ($urandom_range(0, 1) == 1) r = -r;
         if ($urandom_range(0, 15) == 0) r = 24'd0;
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), r);
      end
      step(1'b0, 1'b0, 24'd0);
      check_val("pulse_count", 32'(n_pulses), 32'(n_acc));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
